excp_ctrl: RTL and testbench

Exception and interrupt arbiter at the memory-access stage of the pipeline. Each cycle it resolves the exception flags carried by the retiring instruction against the current CP0 state, and takes the most urgent event. The CP0 `status`/`cause`/`epc` views are forwarded from a pending write-back-stage CP0 write. For a taken event it issues a one-cycle pipeline flush with a redirect PC, and it drives the EPC/Cause/Status update strobes that the CP0 register file consumes. A post-flush hold window blocks re-triggering while the pipeline refills.

---
 rtl/excp_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_excp_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/excp_ctrl.sv
// ---------------------------------------------------------------------------
// excp_ctrl -- MEM-stage exception / interrupt arbiter.
//
// Resolves the retiring instruction's exception flags and pending interrupts
// against the forwarded CP0 view. A taken event produces a one-cycle
// pipeline flush with a redirect PC and the CP0 update strobes. A hold window
// follows during which detection is suppressed while the pipeline refills.
//
// Optional feature: define EXCP_TIMER_INT_EN to OR timer_int_i into Cause[15]
// (IP7) before interrupt evaluation. Without it, timer_int_i is ignored.
//
// Ports:
//   clk, rst (async, active-low)
//   inst_valid_i, inst_addr_i, in_delayslot_i, excp_flags_i, stall_i
//                    MEM-stage instruction info
//                    (flags: [0] syscall, [1] RI, [2] overflow, [3] eret)
//   cp0_status_i, cp0_cause_i, cp0_epc_i    current CP0 values
//   wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i    pending WB-stage CP0 write
//   timer_int_i      timer interrupt level
//   flush_o, new_pc_o, excp_code_o           flush and redirect
//   epc_we_o, epc_o, cause_we_o, cause_bd_o, exl_set_o, exl_clr_o
//                    CP0 update strobes
//   busy_o           high while in FLUSH or HOLD
// ---------------------------------------------------------------------------
module excp_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_addr_i,
    input  logic        in_delayslot_i,
    input  logic [3:0]  excp_flags_i,
    input  logic        stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    input  logic        timer_int_i,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [4:0]  excp_code_o,
    output logic        epc_we_o,
    output logic [31:0] epc_o,
    output logic        cause_we_o,
    output logic        cause_bd_o,
    output logic        exl_set_o,
    output logic        exl_clr_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_HOLD} state_t;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;
    localparam logic [3:0] HOLD_LOAD  = 4'(HOLD_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic        eret_q, eret_d;

    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic        int_pending;
    logic        det_valid, det_eret;
    logic [4:0]  det_code;
    logic        can_detect, take;

    // CP0 forwarding from a pending WB-stage write
    always_comb begin
        status_fwd = cp0_status_i;
        epc_fwd    = cp0_epc_i;
        cause_fwd  = cp0_cause_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) status_fwd = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC)    epc_fwd    = wb_cp0_data_i;
        // Only the software-writable Cause fields are forwarded
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE) begin
            cause_fwd[9:8]   = wb_cp0_data_i[9:8];
            cause_fwd[23:22] = wb_cp0_data_i[23:22];
        end
`ifdef EXCP_TIMER_INT_EN
        cause_fwd[15] = cause_fwd[15] | timer_int_i;
`endif
    end

`ifndef EXCP_TIMER_INT_EN
    logic unused_timer;
    assign unused_timer = timer_int_i;
`endif
    logic unused_bits;
    assign unused_bits = ^{status_fwd[31:16], status_fwd[7:2],
                           cause_fwd[31:16], cause_fwd[7:0]};

    assign int_pending = inst_valid_i && status_fwd[0] && !status_fwd[1]
                         && |(cause_fwd[15:8] & status_fwd[15:8]);

    // Priority encode: interrupt > RI > overflow > syscall > eret
    always_comb begin
        det_valid = 1'b1;
        det_eret  = 1'b0;
        det_code  = 5'h00;
        if (int_pending)                           det_code = 5'h00;
        else if (inst_valid_i && excp_flags_i[1])  det_code = 5'h0A;
        else if (inst_valid_i && excp_flags_i[2])  det_code = 5'h0C;
        else if (inst_valid_i && excp_flags_i[0])  det_code = 5'h08;
        else if (inst_valid_i && excp_flags_i[3])  det_eret = 1'b1;
        else                                       det_valid = 1'b0;
    end

    // The last HOLD cycle behaves like IDLE for detection, so back-to-back
    // flushes are spaced HOLD_CYCLES+1 cycles apart.
    assign can_detect = !stall_i &&
                        (state_q == S_IDLE || (state_q == S_HOLD && cnt_q <= 4'd1));
    assign take = can_detect && det_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            code_q  <= '0;
            epc_q   <= '0;
            bd_q    <= 1'b0;
            eret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
            bd_q    <= bd_d;
            eret_q  <= eret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        code_d  = code_q;
        epc_d   = epc_q;
        bd_d    = bd_q;
        eret_d  = eret_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_FLUSH;
            S_FLUSH: begin
                if (HOLD_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = take ? S_FLUSH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            pc_d   = det_eret ? epc_fwd : EXC_VECTOR;
            code_d = det_code;
            epc_d  = in_delayslot_i ? inst_addr_i - 32'd4 : inst_addr_i;
            bd_d   = in_delayslot_i;
            eret_d = det_eret;
        end
    end

    always_comb begin
        flush_o     = (state_q == S_FLUSH);
        busy_o      = (state_q != S_IDLE);
        new_pc_o    = flush_o ? pc_q : '0;
        excp_code_o = flush_o ? code_q : '0;
        epc_we_o    = flush_o && !eret_q;
        epc_o       = (flush_o && !eret_q) ? epc_q : '0;
        cause_we_o  = flush_o && !eret_q;
        cause_bd_o  = flush_o && !eret_q && bd_q;
        exl_set_o   = flush_o && !eret_q;
        exl_clr_o   = flush_o && eret_q;
    end

endmodule

// File: tb/tb_excp_ctrl.sv
module tb_excp_ctrl;

    logic        clk, rst;
    logic        inst_valid_i, in_delayslot_i, stall_i, wb_cp0_we_i, timer_int_i;
    logic [31:0] inst_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
    logic [3:0]  excp_flags_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic        flush_o, epc_we_o, cause_we_o, cause_bd_o, exl_set_o, exl_clr_o, busy_o;
    logic [31:0] new_pc_o, epc_o;
    logic [4:0]  excp_code_o;

    int n_cmp = 0;
    int n_err = 0;

    excp_ctrl #(.EXC_VECTOR(32'h0000_0020), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .inst_valid_i(inst_valid_i), .inst_addr_i(inst_addr_i),
        .in_delayslot_i(in_delayslot_i), .excp_flags_i(excp_flags_i),
        .stall_i(stall_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
        .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i),
        .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .timer_int_i(timer_int_i), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .excp_code_o(excp_code_o), .epc_we_o(epc_we_o), .epc_o(epc_o),
        .cause_we_o(cause_we_o), .cause_bd_o(cause_bd_o), .exl_set_o(exl_set_o),
        .exl_clr_o(exl_clr_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic        ds;
        logic [3:0]  flags;
        logic        stall;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        wb_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [4:0]  e_code;
        logic        e_epc_we;
        logic [31:0] e_epc;
        logic        e_cause_we;
        logic        e_bd;
        logic        e_set;
        logic        e_clr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        inst_valid_i   = 1'b0;
        inst_addr_i    = '0;
        in_delayslot_i = 1'b0;
        excp_flags_i   = '0;
        stall_i        = 1'b0;
        cp0_status_i   = '0;
        cp0_cause_i    = '0;
        cp0_epc_i      = '0;
        wb_cp0_we_i    = 1'b0;
        wb_cp0_waddr_i = '0;
        wb_cp0_data_i  = '0;
        timer_int_i    = 1'b0;
    endtask

    task automatic settle(input string nm);
        drive_idle();
        repeat (4) tick();
        chk({nm, " settle busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        // valid addr ds flags stall status cause epc wb_we waddr wdata |
        // flush pc code epc_we epc cause_we bd set clr
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 4'b0001, 1'b0, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h08, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 32'h204, 1'b1, 4'b0100, 1'b0, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h0C, 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h600, 1'b0, 4'b1000, 1'b0, 32'hFF01, 32'h0, 32'h300, 1'b1, 5'd14, 32'h400,
                     1'b1, 32'h400, 5'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 32'h600, 1'b0, 4'b1000, 1'b0, 32'hFF01, 32'h0, 32'h300, 1'b1, 5'd12, 32'h0,
                     1'b1, 32'h300, 5'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 32'h500, 1'b0, 4'b0010, 1'b0, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h00, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h500, 1'b0, 4'b0010, 1'b0, 32'h403, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h0A, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 32'h100, 1'b0, 4'b0001, 1'b1, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b0, 32'h0, 5'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h100, 1'b0, 4'b0001, 1'b0, 32'h401, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b0, 32'h0, 5'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 4'b0000, 1'b0, 32'h400, 32'h400, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b0, 32'h0, 5'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h700, 1'b0, 4'b0000, 1'b0, 32'h201, 32'h0, 32'h0, 1'b1, 5'd13, 32'h200,
                     1'b1, 32'h20, 5'h00, 1'b1, 32'h700, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 32'h700, 1'b0, 4'b0000, 1'b0, 32'h801, 32'h0, 32'h0, 1'b1, 5'd13, 32'h800,
                     1'b0, 32'h0, 5'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h710, 1'b0, 4'b0000, 1'b0, 32'h0, 32'h100, 32'h0, 1'b1, 5'd12, 32'h101,
                     1'b1, 32'h20, 5'h00, 1'b1, 32'h710, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 32'h0, 1'b1, 4'b0001, 1'b0, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h08, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 32'h120, 1'b0, 4'b0111, 1'b0, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h0A, 1'b1, 32'h120, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 32'h124, 1'b0, 4'b0101, 1'b0, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h0C, 1'b1, 32'h124, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 32'h128, 1'b0, 4'b1001, 1'b0, 32'hFF01, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                     1'b1, 32'h20, 5'h08, 1'b1, 32'h128, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset state
        drive_idle();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset flush", 32'(flush_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset new_pc", new_pc_o, 32'd0);
        chk("reset code", 32'(excp_code_o), 32'd0);
        chk("reset epc", epc_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        tick();

        // Table-driven single events
        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive_idle();
            inst_valid_i   = vecs[i].valid;
            inst_addr_i    = vecs[i].addr;
            in_delayslot_i = vecs[i].ds;
            excp_flags_i   = vecs[i].flags;
            stall_i        = vecs[i].stall;
            cp0_status_i   = vecs[i].status;
            cp0_cause_i    = vecs[i].cause;
            cp0_epc_i      = vecs[i].epc;
            wb_cp0_we_i    = vecs[i].wb_we;
            wb_cp0_waddr_i = vecs[i].waddr;
            wb_cp0_data_i  = vecs[i].wdata;
            tick();
            chk({nm, " flush"},    32'(flush_o),     32'(vecs[i].e_flush));
            chk({nm, " new_pc"},   new_pc_o,         vecs[i].e_pc);
            chk({nm, " code"},     32'(excp_code_o), 32'(vecs[i].e_code));
            chk({nm, " epc_we"},   32'(epc_we_o),    32'(vecs[i].e_epc_we));
            chk({nm, " epc"},      epc_o,            vecs[i].e_epc);
            chk({nm, " cause_we"}, 32'(cause_we_o),  32'(vecs[i].e_cause_we));
            chk({nm, " bd"},       32'(cause_bd_o),  32'(vecs[i].e_bd));
            chk({nm, " exl_set"},  32'(exl_set_o),   32'(vecs[i].e_set));
            chk({nm, " exl_clr"},  32'(exl_clr_o),   32'(vecs[i].e_clr));
            chk({nm, " busy"},     32'(busy_o),      32'(vecs[i].e_flush));
            settle(nm);
        end

        // Hold window: syscall held for 5 sampled edges
        begin
            logic [4:0] exp_flush;
            exp_flush = 5'b01001; // bit k = cycle k+1
            drive_idle();
            inst_valid_i = 1'b1;
            inst_addr_i  = 32'h100;
            excp_flags_i = 4'b0001;
            cp0_status_i = 32'hFF01;
            for (int c = 0; c < 5; c++) begin
                tick();
                chk($sformatf("hold cyc%0d flush", c + 1), 32'(flush_o), 32'(exp_flush[c]));
                chk($sformatf("hold cyc%0d busy", c + 1), 32'(busy_o), 32'd1);
            end
            settle("hold");
        end

        // FLUSH ignores stall; stall on the last HOLD cycle blocks re-trigger
        drive_idle();
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h140;
        excp_flags_i = 4'b0001;
        cp0_status_i = 32'hFF01;
        tick();
        chk("stall seq flush1", 32'(flush_o), 32'd1);
        stall_i = 1'b1;
        tick();
        chk("stall seq flush ends", 32'(flush_o), 32'd0);
        chk("stall seq busy hold", 32'(busy_o), 32'd1);
        tick();
        tick();
        chk("stall seq idle", 32'(busy_o), 32'd0);
        chk("stall seq no flush", 32'(flush_o), 32'd0);
        stall_i = 1'b0;
        tick();
        chk("stall seq retrigger", 32'(flush_o), 32'd1);
        chk("stall seq epc", epc_o, 32'h140);
        settle("stall seq");

        // Timer interrupt
        drive_idle();
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h180;
        cp0_status_i = 32'h8001;
        timer_int_i  = 1'b1;
        tick();
`ifdef EXCP_TIMER_INT_EN
        chk("timer flush", 32'(flush_o), 32'd1);
        chk("timer code", 32'(excp_code_o), 32'd0);
        chk("timer new_pc", new_pc_o, 32'h20);
`else
        chk("timer flush", 32'(flush_o), 32'd0);
        chk("timer busy", 32'(busy_o), 32'd0);
`endif
        settle("timer");

        // Async reset during FLUSH
        drive_idle();
        inst_valid_i = 1'b1;
        inst_addr_i  = 32'h1C0;
        excp_flags_i = 4'b0010;
        cp0_status_i = 32'hFF01;
        tick();
        chk("rst seq flush", 32'(flush_o), 32'd1);
        drive_idle();
        #2 rst = 1'b0;
        #1;
        chk("rst seq flush", 32'(flush_o), 32'd0);
        chk("rst seq busy", 32'(busy_o), 32'd0);
        chk("rst seq new_pc", new_pc_o, 32'd0);
        chk("rst seq code", 32'(excp_code_o), 32'd0);
        chk("rst seq epc_we", 32'(epc_we_o), 32'd0);
        chk("rst seq exl_set", 32'(exl_set_o), 32'd0);
        chk("rst seq cause_we", 32'(cause_we_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst seq after", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
